// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: branch type encodings and flush counter width
package branch_resolve_unit_pkg;
  typedef enum logic [2:0] {
    BT_BEQ  = 3'd0,
    BT_BNE  = 3'd1,
    BT_BLEZ = 3'd2,
    BT_BGTZ = 3'd3,
    BT_BLTZ = 3'd4,
    BT_BGEZ = 3'd5,
    BT_J    = 3'd6,
    BT_RSV  = 3'd7
  } bt_e;
  localparam int FLUSH_W = 3;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: maps branch type and ALU flags to the take condition
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] bt,
  input  logic       zero,
  input  logic       neg,
  output logic       cond
);
  assign cond = bt == BT_BEQ  ? zero :
                bt == BT_BNE  ? !zero :
                bt == BT_BLEZ ? (neg | zero) :
                bt == BT_BGTZ ? (!neg & !zero) :
                bt == BT_BLTZ ? neg :
                bt == BT_BGEZ ? !neg :
                bt == BT_J;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: MEM-stage branch resolution with flush window and saturating perf counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_STAGES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              Branch,
  input  logic [2:0]        BranchType,
  input  logic              Zero,
  input  logic              Neg,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] TargetPC,
  output logic              flush,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  localparam logic [FLUSH_W-1:0] FS = FLUSH_W'(FLUSH_STAGES);
  logic [FLUSH_W-1:0] fcnt;
  logic cond, valid;
  branch_cond_eval u_cond (
    .bt   (BranchType),
    .zero (Zero),
    .neg  (Neg),
    .cond (cond)
  );
  assign flush    = fcnt != '0;
  assign valid    = Branch & !stall & !flush;
  assign PCSrc    = valid & cond;
  assign TargetPC = PCSrc ? BranchTarget : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt       <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (PCSrc) fcnt <= FS;
      else if (flush && !stall) fcnt <= fcnt - 1'b1;
      if (valid && branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if (PCSrc && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
    end
  end
endmodule
